// File: rtl/disp_share_arb_if.sv
// Client/display bundle for the shared seven-segment arbiter.
// master = client side, slave = arbiter side.
interface disp_share_arb_if;
  logic [3:0]  req;
  logic [63:0] hex_in;
  logic [15:0] dp_in;
  logic [3:0]  gnt;
  logic [3:0]  hex3;
  logic [3:0]  hex2;
  logic [3:0]  hex1;
  logic [3:0]  hex0;
  logic [3:0]  dp_out;
  logic        switch_tick;

  modport master (
    output req, hex_in, dp_in,
    input  gnt, hex3, hex2, hex1, hex0,
    input  dp_out, switch_tick
  );

  modport slave (
    input  req, hex_in, dp_in,
    output gnt, hex3, hex2, hex1, hex0,
    output dp_out, switch_tick
  );
endinterface

// File: rtl/disp_share_arb.sv
// Round-robin time-share of one 4-digit display among 4 clients,
// with a minimum dwell per grant while others contend.
module disp_share_arb #(
  parameter int DWELL = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic       clk,
  input  logic       reset,
  disp_share_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  logic [3:0]       gnt_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;
  logic [3:0]       hex3_q, hex2_q;
  logic [3:0]       hex1_q, hex0_q;
  logic [3:0]       dp_q;
  logic             tick_q;

  logic [1:0] g_idx;
  logic [1:0] scan;
  logic [1:0] pick;
  logic       pick_vld;
  logic       held;
  logic       keep;
  logic [3:0] nxt_gnt;

  always_comb begin
    g_idx = 2'd0;
    unique case (1'b1)
      gnt_q[0]: g_idx = 2'd0;
      gnt_q[1]: g_idx = 2'd1;
      gnt_q[2]: g_idx = 2'd2;
      gnt_q[3]: g_idx = 2'd3;
      default:  g_idx = 2'd0;
    endcase
  end

  // Scan last+1 .. last+4; last+4 wraps to last itself.
  always_comb begin
    scan     = last;
    pick     = last;
    pick_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      scan = last + 2'(i);
      if (!pick_vld && bus.req[scan]) begin
        pick     = scan;
        pick_vld = 1'b1;
      end
    end
  end

  assign held = |gnt_q;
  assign keep = held && bus.req[g_idx]
             && (cnt != CNT_MAX);

  always_comb begin
    nxt_gnt = gnt_q;
    if (!keep)
      nxt_gnt = pick_vld ? (4'd1 << pick) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q  <= 4'd0;
      cnt    <= '0;
      last   <= 2'd3;
      hex3_q <= 4'd0;
      hex2_q <= 4'd0;
      hex1_q <= 4'd0;
      hex0_q <= 4'd0;
      dp_q   <= 4'b1111;
      tick_q <= 1'b0;
    end else begin
      gnt_q  <= nxt_gnt;
      cnt    <= keep ? cnt + CNT_W'(1) : '0;
      if (!keep && pick_vld)
        last <= pick;
      tick_q <= (nxt_gnt != 4'd0)
             && (nxt_gnt != gnt_q);
      if (held) begin
        {hex3_q, hex2_q, hex1_q, hex0_q}
          <= bus.hex_in[{g_idx, 4'b0} +: 16];
        dp_q <= bus.dp_in[{g_idx, 2'b0} +: 4];
      end
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.hex3        = hex3_q;
  assign bus.hex2        = hex2_q;
  assign bus.hex1        = hex1_q;
  assign bus.hex0        = hex0_q;
  assign bus.dp_out      = dp_q;
  assign bus.switch_tick = tick_q;

endmodule

// File: tb/tb_disp_share_arb.sv
// Scoreboard bench for disp_share_arb: directed test-plan
// sequences followed by randomized traffic against a client model.
module tb_disp_share_arb;
  localparam int DW = 4;

  logic clk;
  logic reset;
  disp_share_arb_if bus();

  disp_share_arb #(.DWELL(DW), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  gnt;
    logic        tick;
    logic [15:0] hex;
    logic [3:0]  dp;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  logic [15:0] hx [4];
  logic [3:0]  dpv [4];

  int          owner = -1;
  int          heldc = 0;
  int          rr = 3;
  logic [15:0] m_hex = '0;
  logic [3:0]  m_dp = 4'b1111;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, req_v, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, predict post-edge outputs.
  task automatic step(input logic r, input logic [3:0] rq);
    exp_t e;
    int prev;
    int found;
    @(negedge clk);
    reset = r;
    bus.req = rq;
    bus.hex_in = {hx[3], hx[2], hx[1], hx[0]};
    bus.dp_in = {dpv[3], dpv[2], dpv[1], dpv[0]};
    if (owner >= 0) begin
      m_hex = hx[owner];
      m_dp = dpv[owner];
    end
    e.tick = 1'b0;
    if (r) begin
      owner = -1;
      heldc = 0;
      rr = 3;
      m_hex = '0;
      m_dp = 4'b1111;
    end else begin
      prev = owner;
      if (owner < 0 || !rq[owner] || heldc == DW) begin
        found = -1;
        for (int k = 1; k <= 4; k++)
          if (found < 0 && rq[(rr + k) % 4])
            found = (rr + k) % 4;
        owner = found;
        if (found >= 0) rr = found;
        heldc = 1;
      end else begin
        heldc++;
      end
      e.tick = (owner >= 0) && (owner != prev);
    end
    e.gnt = (owner < 0) ? 4'd0 : 4'(1 << owner);
    e.hex = m_hex;
    e.dp = m_dp;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", 16'(bus.gnt), 16'(e.gnt));
        chk("switch_tick", 16'(bus.switch_tick),
            16'(e.tick));
        chk("hex", {bus.hex3, bus.hex2, bus.hex1,
                    bus.hex0}, e.hex);
        chk("dp_out", 16'(bus.dp_out), 16'(e.dp));
      end
    end
  end

  task automatic rst_n_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b1111);
  endtask

  initial begin
    int r;
    logic [3:0] rq;
    for (int k = 0; k < 4; k++) begin
      hx[k] = 16'h1111 * 16'(k);
      dpv[k] = 4'b1111;
    end
    reset = 1'b1;
    bus.req = '0;
    bus.hex_in = '0;
    bus.dp_in = '1;

    rst_n_cycles(3);
    hx[1] = 16'h1234;
    dpv[1] = 4'b1011;
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0010);

    rst_n_cycles(1);
    hx[0] = 16'hA0A0;
    hx[2] = 16'hC2C2;
    for (int i = 0; i < 14; i++) step(1'b0, 4'b0101);

    rst_n_cycles(1);
    hx[3] = 16'h3D3D;
    step(1'b0, 4'b1001);
    step(1'b0, 4'b1001);
    for (int i = 0; i < 7; i++) step(1'b0, 4'b1000);

    rst_n_cycles(1);
    hx[2] = 16'hBEEF;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001);

    rst_n_cycles(1);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b1001);
    step(1'b0, 4'b1001);
    step(1'b1, 4'b1001);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1001);

    rq = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) rq = 4'($urandom_range(0, 15));
      else if (r < 30) rq[$urandom_range(0, 3)] ^= 1'b1;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) begin
          hx[k] = 16'($urandom);
          dpv[k] = 4'($urandom);
        end
      step($urandom_range(0, 99) < 2, rq);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, expected 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/disp_share_arb.md
# disp_share_arb

Round-robin arbiter that time-shares the single 4-digit seven-segment display between four requesting clients. Each client presents a 16-bit hex value and 4 decimal-point bits. The arbiter grants one client at a time for a guaranteed minimum dwell and drives the winner's digits into `disp_hex_mux` through registers. It sits between application datapaths (adders, counters, status monitors) and `disp_hex_mux` in the board-level test circuits.

## Interface
Parameters:
- `DWELL`, default 100_000_000: minimum granted cycles per client when others contend (≈1 s at 100 MHz); legal range 1..2^CNT_W.
- `CNT_W`, default 27: dwell counter width.

Ports:
- `clk`, input, 1: system clock; one clock domain.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, 4: request per client; bit k is client k.
- `hex_in`, input, 64: client k's value at [16k+15:16k], ordered digit3..digit0 from MSB.
- `dp_in`, input, 16: client k's decimal points at [4k+3:4k]; active-low, passed through unchanged.
- `gnt`, output, 4: registered one-hot grant; 0 when idle.
- `hex3`, `hex2`, `hex1`, `hex0`, output, 4 each: registered digits to `disp_hex_mux`.
- `dp_out`, output, 4: registered decimal points to `disp_hex_mux`.
- `switch_tick`, output, 1: one-cycle pulse on the cycle `gnt` takes a new nonzero value.

## Operation
- Internal state: `gnt` (one-hot or 0), dwell counter `cnt` (CNT_W bits), round-robin pointer `last` (2 bits, index of the most recent grantee).
- rr_pick(mask): scans indices (last+1), (last+2), (last+3), last, all mod 4. It returns the first index whose mask bit is set. Client `last` therefore has the lowest priority, but it wins if it is the only requester.
- Per-edge update, in priority order:
  - `reset`: gnt=0, cnt=0, last=3 (client 0 highest after reset), hex*=0, dp_out=4'b1111, switch_tick=0.
  - IDLE (gnt=0):
    - If any req: gnt ← onehot(rr_pick(req)), last ← picked index, cnt ← 0.
    - Otherwise hold.
  - HOLD, granted client g dropped req[g]:
    - gnt ← onehot(rr_pick(req)) or 0 if req=0; cnt ← 0; last updated only if a new grant is made.
    - Release is immediate; dwell is not enforced on a client that lets go.
  - HOLD, req[g]=1 and cnt=DWELL-1: re-arbitrate with rr_pick(req) starting after g.
    - If g is the only requester, it is re-granted.
    - cnt ← 0 in either case.
  - HOLD otherwise: cnt ← cnt+1.
- `switch_tick` = 1 exactly on edges where the new gnt is nonzero and differs from the previous gnt. Re-granting the same client does not pulse.
- Display registers:
  - Every edge with gnt≠0 (the pre-edge value): {hex3,hex2,hex1,hex0} ← hex_in slice of the granted client, dp_out ← its dp_in slice.
  - Client data is live while granted, so updates appear on the display.
  - When gnt=0: hold the last displayed value; the display never blanks on idle.
- Counter arithmetic: unsigned; cnt never exceeds DWELL-1. With DWELL=1, contending clients rotate every cycle.

## Timing
- req rising sampled at edge t → gnt valid after edge t (1-cycle grant latency).
- Digits for that client valid after edge t+1 (2-cycle request-to-display latency).
- Client data change while granted → visible on hex* one edge later.
- Contended rotation: each client holds gnt for exactly DWELL consecutive cycles, then the grant moves on the same edge. There is no idle gap between grants.
- Simultaneous drop of req[g] and assertion by others: the switch happens on that same edge.
- Reset asserted mid-HOLD: all state returns to reset values on that edge, regardless of req. Arbitration resumes on the first edge after reset deasserts.

## Test plan
Use DWELL=4, CNT_W=3.
- Reset, with req=4'b1111 held during reset → gnt=0, hex*=0, dp_out=4'b1111, switch_tick=0 throughout reset.
- From idle, req=4'b0010, client 1 hex=16'h1234, dp=4'b1011 → gnt=0010 and switch_tick=1 after edge 1; hex3..0=1,2,3,4 and dp_out=1011 after edge 2; gnt stays 0010 indefinitely with no further switch_tick.
- req=4'b0101 right after reset → gnt sequence 0001×4 cycles, 0100×4, 0001×4; switch_tick pulses at each change; displayed digits follow one cycle behind gnt.
- Client 0 granted, req=4'b1001, drop req[0] on the 2nd granted cycle → gnt=1000 on the next edge; client 3 then holds for a full 4 cycles.
- All req drop while client 2 (16'hBEEF) is granted → gnt=0 next edge; hex outputs stay B,E,E,F; a later req=4'b0001 is granted in one cycle.
- Reset asserted at cnt=2 while client 3 is granted and req=4'b1001 → gnt=0 next edge; after release, client 0 is granted first.
